regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the datapath register file: configurable data width, depth and read-port count.
- Adds an optional hardwired-zero entry, a configurable stack-pointer preset and write-to-read bypass.
- Adds a hardware clear sequencer that initialises every entry after reset, replacing simulation-only initialisation.
- Sits in the decode stage of the MIPS datapath. Pipeline control stalls on `busy`.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2^AW entries.
- NRD, 3, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded.
- INIT_IDX, 29, index of the entry preset during clear.
- INIT_VAL, 32'h100, value loaded into INIT_IDX during clear (truncated to DW).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- we, in, 1: write enable.
- wa, in, AW: write address.
- wd, in, DW: write data.
- ra, in, NRD*AW: read addresses; port i = ra[i*AW +: AW].
- rd, out, NRD*DW: read data; port i = rd[i*DW +: DW].
- busy, out, 1: clear sequence in progress.
- wr_drop, out, 1: registered pulse; a write was rejected while busy.

Behaviour:
- Single clock. Reset is asynchronous and active-low: rst_n low immediately forces the reset state, independent of clk.

Reset:
- rst_n low → state CLEAR, clear counter cnt = 0, busy = 1, wr_drop = 0.
- While busy, every rd is forced to 0.
- Array contents are not reset asynchronously; the clear sequence handles them.

FSM, states CLEAR and IDLE:
- CLEAR, each rising edge with rst_n high:
  - write entry[cnt] = (cnt == INIT_IDX) ? INIT_VAL : 0;
  - cnt increments.
  - When cnt == 2^AW-1 is written, go to IDLE.
  - busy is registered: it falls on the edge that writes the last entry. So busy is high for exactly 2^AW cycles after rst_n deasserts (32 cycles at defaults).
- IDLE: terminal until the next reset. busy = 0.
- Reset mid-CLEAR (rst_n low again): cnt returns to 0 and the sequence restarts from entry 0 with full length.

Writes:
- IDLE, we = 1: entry[wa] <= wd at the rising edge.
- If ZERO_REG = 1 and wa = 0, the write has no visible effect; it is not a drop.
- CLEAR, we = 1: write ignored; the clear write has priority. wr_drop = 1 on the following cycle, for one cycle per rejected write. wr_drop = 0 otherwise.

Reads (combinational, zero latency), per port i, in priority order:
1. busy → 0.
2. ZERO_REG && ra_i == 0 → 0.
3. BYPASS && we && ra_i == wa → wd.
4. Otherwise → entry[ra_i].
- With BYPASS = 0, a read of the address being written returns the old value; the new value is visible the cycle after the write edge.
- All NRD ports are independent. Any number of ports may read the same address.
- Widths: addresses are unsigned. INIT_IDX >= 2^AW means no entry is preset. DW < 32 truncates INIT_VAL to its low DW bits.

Test Plan:
1. Release rst_n, read ra = {29, 1, 0} every cycle:
   - busy high for 32 cycles; rd all 0 throughout.
   - After busy falls, rd0 = 0x100, rd1 = 0, rd2 = 0.
2. IDLE: write wa = 5, wd = 0xDEADBEEF, with ra0 = 5 in the same cycle:
   - rd0 = 0xDEADBEEF in that cycle (BYPASS = 1), and held on later cycles with we = 0.
   - With BYPASS = 0, rd0 = 0 in the write cycle and 0xDEADBEEF on the next.
3. Write wa = 0, wd = 0xFFFFFFFF while ra1 = 0:
   - rd1 = 0 in that cycle and afterwards; wr_drop stays 0.
4. Assert we (wa = 3, wd = 7) during cycle 10 of CLEAR:
   - wr_drop = 1 for exactly one cycle, on the next cycle.
   - After clear completes, entry 3 reads 0.
5. Pull rst_n low at CLEAR cycle 20, release after 2 cycles:
   - busy stays high; a full 32-cycle sequence then runs.
   - Entries previously written in IDLE (e.g. entry 5) read 0 afterwards.
6. Parameter sweep DW = 16, AW = 3, NRD = 2, INIT_IDX = 6, INIT_VAL = 0x1234:
   - busy lasts 8 cycles.
   - Afterwards entry 6 reads 0x1234 and all other entries read 0.
   - Concurrent writes and reads on both ports match a reference model over 1000 random cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sequencer run after every reset.
// Reads are combinational (zero latency); writes and the clear take effect at the clock edge.
// No backpressure input; busy stalls the pipeline and writes issued while busy are dropped.
module regfile_mp #(
    parameter int          DW       = 32,
    parameter int          AW       = 5,
    parameter int          NRD      = 3,
    parameter int          ZERO_REG = 1,
    parameter int          INIT_IDX = 29,
    parameter logic [31:0] INIT_VAL = 32'h100,
    parameter int          BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [DW-1:0]      wd,
    input  logic [NRD*AW-1:0]  ra,
    output logic [NRD*DW-1:0]  rd,
    output logic               busy,
    output logic               wr_drop
);

    localparam int            DEPTH  = 1 << AW;
    localparam logic [DW-1:0] INIT_V = DW'(INIT_VAL);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [DW-1:0]     mem_wd;

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = wa;
        mem_wd    = wd;
        case (state_q)
            CLEAR: begin
                // The clear write owns the array port; any user write is rejected.
                mem_we    = 1'b1;
                mem_wa    = cnt_q;
                mem_wd    = (32'(cnt_q) == 32'(INIT_IDX)) ? INIT_V : '0;
                cnt_d     = cnt_q + 1'b1;
                wr_drop_d = we;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                mem_we = we && !((ZERO_REG != 0) && (wa == '0));
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Array has no reset; the clear sequence defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra_i;
        logic [DW-1:0] rd_i;

        assign ra_i = ra[i*AW +: AW];

        always_comb begin
            rd_i = mem_q[ra_i];
            if (busy) begin
                rd_i = '0;
            end else if ((ZERO_REG != 0) && (ra_i == '0)) begin
                rd_i = '0;
            end else if ((BYPASS != 0) && we && (ra_i == wa)) begin
                rd_i = wd;
            end
        end

        assign rd[i*DW +: DW] = rd_i;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized bench for regfile_mp: default, no-bypass and reduced-size configurations.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;

    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [14:0] ra;
    logic [95:0] rd0, rd1;
    logic        busy0, busy1, drop0, drop1;

    logic        we2;
    logic [2:0]  wa2;
    logic [15:0] wd2;
    logic [5:0]  ra2;
    logic [31:0] rd2;
    logic        busy2, drop2;

    int vectors;
    int miscompares;

    // Reference state: array contents, clear progress, pending drop pulse.
    logic [31:0] m0 [32];
    logic [15:0] m2 [8];
    int          cnt0, cnt2;
    logic        drop0_exp, drop2_exp;

    regfile_mp u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd0), .busy(busy0), .wr_drop(drop0)
    );

    regfile_mp #(.BYPASS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd1), .busy(busy1), .wr_drop(drop1)
    );

    regfile_mp #(.DW(16), .AW(3), .NRD(2), .INIT_IDX(6), .INIT_VAL(32'h1234)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2),
        .rd(rd2[31:0]), .busy(busy2), .wr_drop(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e0(input logic [4:0] a, input bit byp);
        if (cnt0 < 32)                 return 32'h0;
        if (a == 5'd0)                 return 32'h0;
        if (byp && we && a == wa)      return wd;
        return m0[a];
    endfunction

    function automatic logic [15:0] e2(input logic [2:0] a);
        if (cnt2 < 8)                  return 16'h0;
        if (a == 3'd0)                 return 16'h0;
        if (we2 && a == wa2)           return wd2;
        return m2[a];
    endfunction

    task automatic check_all();
        #1;
        chk("busy0", 32'(busy0), 32'(cnt0 < 32));
        chk("busy1", 32'(busy1), 32'(cnt0 < 32));
        chk("drop0", 32'(drop0), 32'(drop0_exp));
        chk("drop1", 32'(drop1), 32'(drop0_exp));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_byp[%0d]", i), rd0[i*32 +: 32], e0(ra[i*5 +: 5], 1'b1));
            chk($sformatf("rd_nobyp[%0d]", i), rd1[i*32 +: 32], e0(ra[i*5 +: 5], 1'b0));
        end
        chk("busy2", 32'(busy2), 32'(cnt2 < 8));
        chk("drop2", 32'(drop2), 32'(drop2_exp));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_small[%0d]", i), 32'(rd2[i*16 +: 16]), 32'(e2(ra2[i*3 +: 3])));
        end
    endtask

    // Advance one clock and apply what the array saw at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            drop0_exp = 1'b0;
            drop2_exp = 1'b0;
        end else begin
            if (cnt0 < 32) begin
                m0[cnt0]  = (cnt0 == 29) ? 32'h100 : 32'h0;
                drop0_exp = we;
                cnt0++;
            end else begin
                drop0_exp = 1'b0;
                if (we && wa != 5'd0) m0[wa] = wd;
            end
            if (cnt2 < 8) begin
                m2[cnt2]  = (cnt2 == 6) ? 16'h1234 : 16'h0;
                drop2_exp = we2;
                cnt2++;
            end else begin
                drop2_exp = 1'b0;
                if (we2 && wa2 != 3'd0) m2[wa2] = wd2;
            end
        end
    endtask

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            cnt0      = 0;
            cnt2      = 0;
            drop0_exp = 1'b0;
            drop2_exp = 1'b0;
        end
    endtask

    initial begin
        int bl, bl2, dc;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) m0[i] = 32'h0;
        for (int i = 0; i < 8; i++)  m2[i] = 16'h0;
        cnt0 = 0; cnt2 = 0; drop0_exp = 1'b0; drop2_exp = 1'b0;
        we = 1'b0; wa = '0; wd = '0; ra = '0;
        we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
        rst_n = 1'b1;
        #1 set_rst(1'b0);

        check_all();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all();
        end
        set_rst(1'b1);

        // Clear after release: ports read {29, 1, 0}.
        ra  = {5'd0, 5'd1, 5'd29};
        ra2 = {3'd1, 3'd6};
        bl = 0; bl2 = 0;
        for (int i = 0; i < 40; i++) begin
            check_all();
            if (busy0) bl++;
            if (busy2) bl2++;
            tick();
        end
        check_all();
        chk("t1_busy_len", bl, 32);
        chk("t6_busy_len", bl2, 8);
        chk("t1_rd0", rd0[31:0], 32'h100);
        chk("t1_rd1", rd0[63:32], 32'h0);
        chk("t1_rd2", rd0[95:64], 32'h0);
        tick();

        // Write with same-cycle read of the written address.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd0, 5'd5};
        check_all();
        chk("t2_bypass", rd0[31:0], 32'hDEADBEEF);
        chk("t2_nobypass", rd1[31:0], 32'h0);
        tick();
        we = 1'b0;
        check_all();
        chk("t2_hold_byp", rd0[31:0], 32'hDEADBEEF);
        chk("t2_hold_nobyp", rd1[31:0], 32'hDEADBEEF);
        tick();

        // Write to the hardwired-zero entry.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        check_all();
        chk("t3_rd1_now", rd0[63:32], 32'h0);
        tick();
        we = 1'b0;
        check_all();
        chk("t3_rd1_after", rd0[63:32], 32'h0);
        chk("t3_no_drop", 32'(drop0), 32'h0);
        tick();

        // Write attempted during clear cycle 10.
        set_rst(1'b0);
        check_all();
        tick();
        set_rst(1'b1);
        ra = {5'd0, 5'd0, 5'd3};
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            we = (i == 10); wa = 5'd3; wd = 32'd7;
            check_all();
            if (drop0) dc++;
            tick();
        end
        we = 1'b0;
        check_all();
        chk("t4_drop_pulses", dc, 1);
        chk("t4_entry3", rd0[31:0], 32'h0);
        tick();

        // Re-populate entry 5, then reset in the middle of a clear.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        check_all();
        tick();
        we = 1'b0;
        set_rst(1'b0);
        check_all();
        tick();
        set_rst(1'b1);
        ra = {5'd0, 5'd0, 5'd5};
        bl = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) set_rst(1'b0);
            if (i == 22) set_rst(1'b1);
            check_all();
            if (busy0) bl++;
            tick();
        end
        check_all();
        chk("t5_busy_len", bl, 54);
        chk("t5_entry5", rd0[31:0], 32'h0);
        tick();

        // Small configuration: every entry after clear.
        for (int e = 0; e < 8; e += 2) begin
            ra2 = {3'(e + 1), 3'(e)};
            check_all();
            chk($sformatf("t6_entry%0d", e), 32'(rd2[15:0]), (e == 6) ? 32'h1234 : 32'h0);
            chk($sformatf("t6_entry%0d", e + 1), 32'(rd2[31:16]), 32'h0);
            tick();
        end

        // Random concurrent writes and reads on all instances.
        for (int n = 0; n < 1000; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom);
            wd  = $urandom;
            ra  = 15'($urandom);
            if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
            we2 = 1'($urandom_range(0, 1));
            wa2 = 3'($urandom);
            wd2 = 16'($urandom);
            ra2 = 6'($urandom);
            check_all();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
